piso_serializer: RTL and testbench

//   Parallel-in, serial-out shift register: the transmit end of the team's serial bit-stream link.

---
 rtl/piso_serializer.sv | 98 +++++++++
 tb/tb_piso_serializer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: transmit end of the serial bit-stream link.
// Loads a word on valid/ready, emits one bit per shift_enable edge, then pulses done.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_enable,
  output logic             serial_out,
  output logic             frame_active,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_nx;
  logic [CW-1:0]    count_q;
  logic             done_q;
  logic             accept;
  logic             advance;
  logic             last;
  logic             head_bit;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_enable) begin
          if (count_q == LAST) begin
            last    = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift toward the output end with zero fill.
  assign shreg_nx = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};
  assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        shreg_q <= load_data;
        count_q <= '0;
      end else if (advance) begin
        shreg_q <= shreg_nx;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign load_ready   = (state_q == IDLE);
  assign frame_active = (state_q == SHIFT);
  assign serial_out   = frame_active & head_bit;
  assign done         = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer (WIDTH=4).
// MSB-first and LSB-first instances share stimulus; use_lsb picks which is checked.
module tb_piso_serializer;

  logic       clock;
  logic       reset;
  logic       load_valid;
  logic [3:0] load_data;
  logic       shift_enable;

  logic lr_m, so_m, fa_m, dn_m;
  logic lr_l, so_l, fa_l, dn_l;

  logic use_lsb;
  logic lr_s, so_s, fa_s, dn_s;

  int   checks;
  int   failures;
  logic exp_q[$];
  logic eb;
  logic [3:0] rx;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (lr_m),
    .load_data   (load_data),
    .shift_enable(shift_enable),
    .serial_out  (so_m),
    .frame_active(fa_m),
    .done        (dn_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (lr_l),
    .load_data   (load_data),
    .shift_enable(shift_enable),
    .serial_out  (so_l),
    .frame_active(fa_l),
    .done        (dn_l)
  );

  assign lr_s = use_lsb ? lr_l : lr_m;
  assign so_s = use_lsb ? so_l : so_m;
  assign fa_s = use_lsb ? fa_l : fa_m;
  assign dn_s = use_lsb ? dn_l : dn_m;

  always #5 clock = ~clock;

  // Drives a one-cycle handshake and queues the bits in wire order.
  task automatic load_word(input logic [3:0] w, input bit keep_valid);
    load_data  = w;
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(use_lsb ? w[i] : w[3-i]);
    @(negedge clock);
    if (!keep_valid) load_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (so_m !== 1'b0) begin
      failures++; $display("FAIL rst_serial_out got=%b exp=0", so_m);
    end
    checks++;
    if (fa_m !== 1'b0) begin
      failures++; $display("FAIL rst_frame_active got=%b exp=0", fa_m);
    end
    checks++;
    if (dn_m !== 1'b0) begin
      failures++; $display("FAIL rst_done got=%b exp=0", dn_m);
    end
    checks++;
    if (lr_m !== 1'b1) begin
      failures++; $display("FAIL rst_load_ready got=%b exp=1", lr_m);
    end
    @(negedge clock);
    load_valid   = 1'b1;
    load_data    = 4'b1011;
    shift_enable = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (fa_m !== 1'b0 || fa_l !== 1'b0) begin
      failures++; $display("FAIL rst_no_accept got=%b%b exp=00", fa_m, fa_l);
    end
    load_valid = 1'b0;
    reset      = 1'b0;
    for (int c = 0; c < 6; c++) begin
      shift_enable = c[0];
      @(negedge clock);
      checks++;
      if (so_m !== 1'b0 || fa_m !== 1'b0 || dn_m !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet so=%b fa=%b dn=%b exp=000", so_m, fa_m, dn_m);
      end
    end
  endtask

  task automatic test_msb_continuous;
    bit fin;
    use_lsb = 1'b0;
    fin = 1'b0;
    load_word(4'b1011, 1'b0);
    for (int c = 0; c < 40 && !fin; c++) begin
      if (fa_s) begin
        eb = (exp_q.size() != 0) ? exp_q[0] : 1'bx;
        checks++;
        if (so_s !== eb) begin
          failures++; $display("FAIL cont_bit got=%b exp=%b", so_s, eb);
        end
        checks++;
        if (dn_s !== 1'b0 || lr_s !== 1'b0) begin
          failures++; $display("FAIL cont_flags dn=%b lr=%b exp=00", dn_s, lr_s);
        end
        shift_enable = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clock);
      end else begin
        fin = 1'b1;
        checks++;
        if (dn_s !== 1'b1 || lr_s !== 1'b1 || so_s !== 1'b0 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL cont_end dn=%b lr=%b so=%b left=%0d exp=1,1,0,0",
                   dn_s, lr_s, so_s, exp_q.size());
        end
      end
    end
    checks++;
    if (!fin) begin
      failures++; $display("FAIL cont_timeout got=active exp=done");
    end
    @(negedge clock);
    checks++;
    if (dn_s !== 1'b0 || lr_s !== 1'b1) begin
      failures++; $display("FAIL cont_after dn=%b lr=%b exp=0,1", dn_s, lr_s);
    end
    exp_q.delete();
  endtask

  task automatic test_enable_spacing;
    bit fin;
    int k;
    use_lsb = 1'b0;
    fin = 1'b0;
    k = 0;
    shift_enable = 1'b0;
    load_word(4'b1011, 1'b0);
    for (int c = 0; c < 60 && !fin; c++) begin
      if (fa_s) begin
        eb = (exp_q.size() != 0) ? exp_q[0] : 1'bx;
        checks++;
        if (so_s !== eb) begin
          failures++; $display("FAIL space_bit k=%0d got=%b exp=%b", k, so_s, eb);
        end
        checks++;
        if (dn_s !== 1'b0) begin
          failures++; $display("FAIL space_early_done got=%b exp=0", dn_s);
        end
        shift_enable = ((k % 3) == 2);
        k++;
        if (shift_enable && exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clock);
      end else begin
        fin = 1'b1;
        checks++;
        if (dn_s !== 1'b1 || exp_q.size() != 0 || k != 12) begin
          failures++;
          $display("FAIL space_end dn=%b left=%0d cycles=%0d exp=1,0,12",
                   dn_s, exp_q.size(), k);
        end
      end
    end
    checks++;
    if (!fin) begin
      failures++; $display("FAIL space_timeout got=active exp=done");
    end
    shift_enable = 1'b0;
    @(negedge clock);
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    bit fin;
    use_lsb = 1'b0;
    for (int f = 0; f < 2; f++) begin
      fin = 1'b0;
      if (f == 0) begin
        load_word(4'b1011, 1'b1);
        load_data = 4'b0110;
      end else begin
        checks++;
        if (fa_s !== 1'b1) begin
          failures++; $display("FAIL b2b_accept got=%b exp=1", fa_s);
        end
      end
      for (int c = 0; c < 40 && !fin; c++) begin
        if (fa_s) begin
          eb = (exp_q.size() != 0) ? exp_q[0] : 1'bx;
          checks++;
          if (so_s !== eb) begin
            failures++; $display("FAIL b2b_bit f=%0d got=%b exp=%b", f, so_s, eb);
          end
          checks++;
          if (lr_s !== 1'b0) begin
            failures++; $display("FAIL b2b_ready got=%b exp=0", lr_s);
          end
          shift_enable = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          @(negedge clock);
        end else begin
          fin = 1'b1;
          checks++;
          if (dn_s !== 1'b1 || lr_s !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_end f=%0d dn=%b lr=%b left=%0d exp=1,1,0",
                     f, dn_s, lr_s, exp_q.size());
          end
        end
      end
      checks++;
      if (!fin) begin
        failures++; $display("FAIL b2b_timeout f=%0d got=active exp=done", f);
      end
      exp_q.delete();
      if (f == 0) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(load_data[3-i]);
      end
      @(negedge clock);
      load_valid = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    bit fin;
    use_lsb = 1'b0;
    shift_enable = 1'b1;
    load_word(4'b1011, 1'b0);
    for (int c = 0; c < 2; c++) begin
      eb = exp_q[0];
      checks++;
      if (so_s !== eb || fa_s !== 1'b1) begin
        failures++; $display("FAIL mid_pre_bit got=%b fa=%b exp=%b,1", so_s, fa_s, eb);
      end
      void'(exp_q.pop_front());
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (so_s !== 1'b0 || fa_s !== 1'b0 || dn_s !== 1'b0 || lr_s !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset so=%b fa=%b dn=%b lr=%b exp=0,0,0,1",
               so_s, fa_s, dn_s, lr_s);
    end
    exp_q.delete();
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = 4'b0101;
    @(negedge clock);
    load_valid = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (dn_s !== 1'b0 || fa_s !== 1'b0) begin
        failures++; $display("FAIL mid_resume dn=%b fa=%b exp=0,0", dn_s, fa_s);
      end
    end
    fin = 1'b0;
    load_word(4'b1100, 1'b0);
    for (int c = 0; c < 40 && !fin; c++) begin
      if (fa_s) begin
        eb = (exp_q.size() != 0) ? exp_q[0] : 1'bx;
        checks++;
        if (so_s !== eb) begin
          failures++; $display("FAIL mid_next_bit got=%b exp=%b", so_s, eb);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clock);
      end else begin
        fin = 1'b1;
        checks++;
        if (dn_s !== 1'b1 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL mid_next_end dn=%b left=%0d exp=1,0", dn_s, exp_q.size());
        end
      end
    end
    checks++;
    if (!fin) begin
      failures++; $display("FAIL mid_timeout got=active exp=done");
    end
    @(negedge clock);
    exp_q.delete();
  endtask

  task automatic test_lsb_loopback;
    bit fin;
    int k;
    use_lsb = 1'b1;
    fin = 1'b0;
    k = 0;
    rx = 4'b0000;
    shift_enable = 1'b0;
    load_word(4'b1011, 1'b0);
    for (int c = 0; c < 40 && !fin; c++) begin
      if (fa_s) begin
        eb = (exp_q.size() != 0) ? exp_q[0] : 1'bx;
        checks++;
        if (so_s !== eb) begin
          failures++; $display("FAIL lsb_bit got=%b exp=%b", so_s, eb);
        end
        shift_enable = k[0];
        k++;
        if (shift_enable) begin
          rx = {so_s, rx[3:1]};
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        @(negedge clock);
      end else begin
        fin = 1'b1;
        checks++;
        if (dn_s !== 1'b1 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL lsb_end dn=%b left=%0d exp=1,0", dn_s, exp_q.size());
        end
      end
    end
    checks++;
    if (!fin) begin
      failures++; $display("FAIL lsb_timeout got=active exp=done");
    end
    checks++;
    if (rx !== 4'b1011) begin
      failures++; $display("FAIL lsb_loopback got=%b exp=1011", rx);
    end
    shift_enable = 1'b0;
    @(negedge clock);
    exp_q.delete();
  endtask

  initial begin
    clock        = 1'b0;
    reset        = 1'b1;
    load_valid   = 1'b0;
    load_data    = 4'b0000;
    shift_enable = 1'b0;
    use_lsb      = 1'b0;
    checks       = 0;
    failures     = 0;
    test_reset();
    test_msb_continuous();
    test_enable_spacing();
    test_back_to_back();
    test_reset_mid_frame();
    test_lsb_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
